// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong constants, FSM state encoding and direction codes
package pong_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  // Wide enough for any on-screen coordinate plus one signed step past either edge.
  typedef logic signed [10:0] coord_t;

  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    coord_t d;
    d = a - b;
    return (d < 0) ? -d : d;
  endfunction

endpackage

// File: rtl/ball_ctrl_if.sv
// rtl/ball_ctrl_if.sv - frame/paddle inputs and ball sprite outputs of the ball controller
interface ball_ctrl_if;
  logic       frame;
  logic       pause;
  logic [8:0] pad_l_y;
  logic [8:0] pad_r_y;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       serving;
  logic       score_l;
  logic       score_r;

  modport master (
    output frame, pause, pad_l_y, pad_r_y,
    input  ball_x, ball_y, serving, score_l, score_r
  );

  modport slave (
    input  frame, pause, pad_l_y, pad_r_y,
    output ball_x, ball_y, serving, score_l, score_r
  );
endinterface

// File: rtl/ball_collide.sv
// rtl/ball_collide.sv - combinational one-frame ball step with wall, paddle and miss resolution
module ball_collide
  import pong_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int BALL_SIZE  = 10,
  parameter int PADDLE_W   = 10,
  parameter int PADDLE_H   = 60,
  parameter int PADDLE_L_X = 20,
  parameter int PADDLE_R_X = 620
) (
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  input  logic       dx_i,
  input  logic       dy_i,
  input  logic [2:0] spd_i,
  input  logic [8:0] pad_l_y_i,
  input  logic [8:0] pad_r_y_i,
  output logic [9:0] x_o,
  output logic [8:0] y_o,
  output logic       dx_o,
  output logic       dy_o,
  output logic       hit_l_o,
  output logic       hit_r_o,
  output logic       miss_l_o,
  output logic       miss_r_o
);

  localparam coord_t HB     = coord_t'(BALL_SIZE / 2);
  localparam coord_t Y_MAX  = coord_t'(V_RES - 1 - BALL_SIZE / 2);
  localparam coord_t X_MAX  = coord_t'(H_RES - 1 - BALL_SIZE / 2);
  localparam coord_t L_FACE = coord_t'(PADDLE_L_X + PADDLE_W / 2);
  localparam coord_t R_FACE = coord_t'(PADDLE_R_X - PADDLE_W / 2);
  localparam coord_t REACH  = coord_t'((PADDLE_H + BALL_SIZE) / 2);

  localparam logic [8:0] Y_TOP   = 9'(BALL_SIZE / 2);
  localparam logic [8:0] Y_BOT   = 9'(V_RES - 1 - BALL_SIZE / 2);
  localparam logic [9:0] X_HIT_L = 10'(PADDLE_L_X + PADDLE_W / 2 + BALL_SIZE / 2);
  localparam logic [9:0] X_HIT_R = 10'(PADDLE_R_X - PADDLE_W / 2 - BALL_SIZE / 2);

  coord_t cx, cy, step, nx, ny;

  always_comb begin
    cx   = {1'b0, x_i};
    cy   = {2'b00, y_i};
    step = {8'd0, spd_i};
    nx   = (dx_i == DIR_RIGHT) ? cx + step : cx - step;
    ny   = (dy_i == DIR_DOWN) ? cy + step : cy - step;

    y_o  = ny[8:0];
    dy_o = dy_i;
    if (ny <= HB) begin
      y_o  = Y_TOP;
      dy_o = DIR_DOWN;
    end else if (ny >= Y_MAX) begin
      y_o  = Y_BOT;
      dy_o = DIR_UP;
    end

    // Paddle overlap is judged on the pre-move row, the miss on the post-move column.
    hit_l_o  = (dx_i == DIR_LEFT) && (nx - HB <= L_FACE)
               && (abs_diff(cy, {2'b00, pad_l_y_i}) < REACH);
    hit_r_o  = (dx_i == DIR_RIGHT) && (nx + HB >= R_FACE)
               && (abs_diff(cy, {2'b00, pad_r_y_i}) < REACH);
    miss_l_o = (dx_i == DIR_LEFT) && !hit_l_o && (nx <= HB);
    miss_r_o = (dx_i == DIR_RIGHT) && !hit_r_o && (nx >= X_MAX);

    x_o  = nx[9:0];
    dx_o = dx_i;
    if (hit_l_o) begin
      x_o  = X_HIT_L;
      dx_o = DIR_RIGHT;
    end else if (hit_r_o) begin
      x_o  = X_HIT_R;
      dx_o = DIR_LEFT;
    end else if (miss_l_o || miss_r_o) begin
      x_o = x_i;
    end
  end

endmodule

// File: rtl/ball_ctrl.sv
// rtl/ball_ctrl.sv - per-frame ball sequencer (serve/play/scored); BALL_CTRL_SPEEDUP_EN enables paddle speed-up
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF,
  parameter int BALL_SIZE   = 10,
  parameter int PADDLE_W    = 10,
  parameter int PADDLE_H    = 60,
  parameter int PADDLE_L_X  = 20,
  parameter int PADDLE_R_X  = 620,
  parameter int SPEED       = 2,
  parameter int MAX_SPEED   = 6,
  parameter int SERVE_DELAY = 60
) (
  input logic        clk,
  input logic        rst,
  ball_ctrl_if.slave bus
);

  localparam logic [9:0] X_CTR      = 10'(H_RES / 2);
  localparam logic [8:0] Y_CTR      = 9'(V_RES / 2);
  localparam logic [2:0] SPD_INIT   = 3'(SPEED);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY - 1);

  if (SPEED < 1 || SPEED > 7 || MAX_SPEED < 1 || MAX_SPEED > 7 || (BALL_SIZE % 2) != 0)
  begin : g_cfg_err
    $error("ball_ctrl: speed must be 1..7 and ball size even");
  end

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic [2:0] spd_q, spd_d, spd_hit;
  logic       score_l_q, score_l_d, score_r_q, score_r_d;

  logic       frame_ok;
  logic [9:0] cx;
  logic [8:0] cy;
  logic       cdx, cdy, hit_l, hit_r, miss_l, miss_r;

  assign frame_ok = bus.frame & ~bus.pause;

  ball_collide #(
    .H_RES(H_RES), .V_RES(V_RES), .BALL_SIZE(BALL_SIZE), .PADDLE_W(PADDLE_W),
    .PADDLE_H(PADDLE_H), .PADDLE_L_X(PADDLE_L_X), .PADDLE_R_X(PADDLE_R_X)
  ) u_collide (
    .x_i(x_q), .y_i(y_q), .dx_i(dx_q), .dy_i(dy_q), .spd_i(spd_q),
    .pad_l_y_i(bus.pad_l_y), .pad_r_y_i(bus.pad_r_y),
    .x_o(cx), .y_o(cy), .dx_o(cdx), .dy_o(cdy),
    .hit_l_o(hit_l), .hit_r_o(hit_r), .miss_l_o(miss_l), .miss_r_o(miss_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SERVE;
      cnt_q     <= '0;
      x_q       <= X_CTR;
      y_q       <= Y_CTR;
      dx_q      <= DIR_RIGHT;
      dy_q      <= DIR_DOWN;
      spd_q     <= SPD_INIT;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      spd_q     <= spd_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    spd_d     = spd_q;
    score_l_d = 1'b0;
    score_r_d = 1'b0;
`ifdef BALL_CTRL_SPEEDUP_EN
    spd_hit   = (spd_q < 3'(MAX_SPEED)) ? spd_q + 3'd1 : 3'(MAX_SPEED);
`else
    spd_hit   = SPD_INIT;
`endif

    case (state_q)
      ST_SERVE: begin
        if (frame_ok) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_PLAY: begin
        if (frame_ok) begin
          if (miss_l) begin
            state_d   = ST_SCORED;
            score_r_d = 1'b1;
          end else if (miss_r) begin
            state_d   = ST_SCORED;
            score_l_d = 1'b1;
          end else begin
            x_d  = cx;
            y_d  = cy;
            dx_d = cdx;
            dy_d = cdy;
            if (hit_l || hit_r) spd_d = spd_hit;
          end
        end
      end
      ST_SCORED: begin
        // Serve toward whoever conceded the point.
        state_d = ST_SERVE;
        cnt_d   = '0;
        x_d     = X_CTR;
        y_d     = Y_CTR;
        dx_d    = score_r_q ? DIR_LEFT : DIR_RIGHT;
        spd_d   = SPD_INIT;
      end
      default: state_d = ST_SERVE;
    endcase
  end

  assign bus.ball_x  = x_q;
  assign bus.ball_y  = y_q;
  assign bus.serving = (state_q == ST_SERVE);
  assign bus.score_l = score_l_q;
  assign bus.score_r = score_r_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// tb/tb_ball_ctrl.sv - randomized scoreboard bench for ball_ctrl against a frame-level reference model
module tb_ball_ctrl;

  logic clk = 1'b0;
  logic rst;
  ball_ctrl_if bif ();

  ball_ctrl dut (.clk(clk), .rst(rst), .bus(bif));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cyc;
    int          x;
    int          y;
    bit          serving;
    bit          sl;
    bit          sr;
  } exp_t;
  exp_t exp_q[$];

  localparam int SPEED = 2;
  localparam int MAX_SPEED = 6;

  // Reference model: mode 0 = serving, 1 = in play, 2 = point just scored.
  int m_mode, m_x, m_y, m_vx, m_vy, m_spd, m_cnt;
  bit m_sl, m_sr, m_left_conceded, m_hit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model_step(input bit r, input bit f, input bit p, input int pl, input int pr);
    int nx, ny, tx, ty, tvx, tvy;
    bit hl, hr;
    m_sl  = 0;
    m_sr  = 0;
    m_hit = 0;
    if (r) begin
      m_mode = 0; m_cnt = 0; m_x = 320; m_y = 240;
      m_vx = 1; m_vy = 1; m_spd = SPEED;
      return;
    end
    if (m_mode == 2) begin
      m_mode = 0; m_cnt = 0; m_x = 320; m_y = 240;
      m_vx = m_left_conceded ? -1 : 1;
      m_spd = SPEED;
      return;
    end
    if (!f || p) return;
    if (m_mode == 0) begin
      m_cnt++;
      if (m_cnt == 60) begin
        m_cnt  = 0;
        m_mode = 1;
      end
      return;
    end
    nx = m_x + m_vx * m_spd;
    ny = m_y + m_vy * m_spd;
    ty = ny; tvy = m_vy;
    if (ny <= 5) begin
      ty = 5; tvy = 1;
    end else if (ny >= 474) begin
      ty = 474; tvy = -1;
    end
    hl = (m_vx < 0) && (nx - 5 <= 25) && (iabs(m_y - pl) < 35);
    hr = (m_vx > 0) && (nx + 5 >= 615) && (iabs(m_y - pr) < 35);
    tx = nx; tvx = m_vx;
    if (hl) begin
      tx = 30; tvx = 1;
    end else if (hr) begin
      tx = 610; tvx = -1;
    end else if (m_vx < 0 && nx <= 5) begin
      m_mode = 2; m_sr = 1; m_left_conceded = 1;
      return;
    end else if (m_vx > 0 && nx >= 634) begin
      m_mode = 2; m_sl = 1; m_left_conceded = 0;
      return;
    end
    m_x = tx; m_y = ty; m_vx = tvx; m_vy = tvy;
    if (hl || hr) begin
      m_hit = 1;
`ifdef BALL_CTRL_SPEEDUP_EN
      m_spd = (m_spd + 1 > MAX_SPEED) ? MAX_SPEED : m_spd + 1;
`endif
    end
  endfunction

  task automatic push_expect();
    exp_t e;
    e.cyc     = cyc + 1;
    e.x       = m_x;
    e.y       = m_y;
    e.serving = (m_mode == 0);
    e.sl      = m_sl;
    e.sr      = m_sr;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("ball_x", 32'(bif.ball_x), e.x);
        check("ball_y", 32'(bif.ball_y), e.y);
        check("serving", 32'(bif.serving), 32'(e.serving));
        check("score_l", 32'(bif.score_l), 32'(e.sl));
        check("score_r", 32'(bif.score_r), 32'(e.sr));
      end
    end
  end

  initial begin
    bit rally_miss;
    int pl, pr, near_y, far_y;
    bit f, p, r;

    rally_miss  = 0;
    rst         = 1'b1;
    bif.frame   = 1'b0;
    bif.pause   = 1'b0;
    bif.pad_l_y = 9'd240;
    bif.pad_r_y = 9'd240;
    model_step(1'b1, 1'b0, 1'b0, 240, 240);
    push_expect();

    for (int i = 0; i < 16000; i++) begin
      @(posedge clk);
      #1;
      r = (i < 3) || (i == 9000);
      f = (i == 9000) ? 1'b1 : ($urandom_range(0, 1) == 1);
      p = (i >= 5000 && i < 5040) ? 1'b1 : ($urandom_range(0, 9) == 0);

      near_y = m_y + $urandom_range(0, 70) - 35;
      if (near_y < 0) near_y = 0;
      if (near_y > 479) near_y = 479;
      far_y = (m_y + 240) % 480;
      pl = rally_miss ? far_y : near_y;
      pr = rally_miss ? far_y : near_y;

      rst         = r;
      bif.frame   = f;
      bif.pause   = p;
      bif.pad_l_y = 9'(pl);
      bif.pad_r_y = 9'(pr);

      model_step(r, f, p, pl, pr);
      push_expect();
      if (m_hit || m_mode == 2) rally_miss = ($urandom_range(0, 3) == 0);
    end

    @(posedge clk);
    #1;
    rst       = 1'b0;
    bif.frame = 1'b0;
    bif.pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_ctrl.md
# ball_ctrl

Frame-rate controller that sequences the ball sprite for the pong datapath. It owns the ball's centre position and direction, and advances both once per video frame. It resolves collisions against the walls and both paddles, raises score events, and runs the serve delay after each point. Its `ball_x`/`ball_y` outputs feed the sprite renderer's centre-coordinate inputs directly.

## Interface
Parameters:
- `H_RES`, 640: visible width in pixels.
- `V_RES`, 480: visible height in pixels.
- `BALL_SIZE`, 10: ball edge length. Must be even.
- `PADDLE_W`, 10: paddle width.
- `PADDLE_H`, 60: paddle height.
- `PADDLE_L_X`, 20: left paddle centre x.
- `PADDLE_R_X`, 620: right paddle centre x.
- `SPEED`, 2: pixels moved per frame on each axis. Range 1..7.
- `MAX_SPEED`, 6: speed ceiling. Used only with speed-up enabled.
- `SERVE_DELAY`, 60: frames the ball holds at centre before play.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `frame` in 1: one-cycle pulse at the start of vertical blanking.
- `pause` in 1: while high, `frame` pulses are ignored.
- `pad_l_y` in 9: left paddle centre y.
- `pad_r_y` in 9: right paddle centre y.
- `ball_x` out 10: ball centre x. Registered.
- `ball_y` out 9: ball centre y. Registered.
- `serving` out 1: high while in SERVE.
- `score_l` out 1: one-cycle pulse when the left player scores.
- `score_r` out 1: one-cycle pulse when the right player scores.

## Operation
- States: SERVE, PLAY, SCORED.
- Direction registers: `dx` (0 = left, 1 = right) and `dy` (0 = up, 1 = down).
- Speed register `spd` (3 bits).
- Serve counter: 8 bits.
- SERVE behaviour:
  - Ball sits at (H_RES/2, V_RES/2).
  - Each accepted `frame` increments the counter.
  - On the SERVE_DELAY-th accepted frame: clear the counter and go to PLAY. The ball does not move on that frame.
- PLAY, on each accepted `frame`: nx = x ± spd, ny = y ± spd.
  - Compute in 11-bit signed arithmetic; no wrap is permitted.
- Vertical walls:
  - If ny ≤ BALL_SIZE/2: set y = BALL_SIZE/2, dy = 1.
  - If ny ≥ V_RES−1−BALL_SIZE/2: clamp y to that value, dy = 0.
- Left paddle hit requires all of:
  - dx = 0;
  - nx − BALL_SIZE/2 ≤ PADDLE_L_X + PADDLE_W/2;
  - |y − pad_l_y| < (PADDLE_H + BALL_SIZE)/2.
  - Result: x = PADDLE_L_X + PADDLE_W/2 + BALL_SIZE/2, dx = 1.
- Right paddle hit mirrors the left, using PADDLE_R_X and `pad_r_y`.
- If dx = 0, no paddle hit, and nx ≤ BALL_SIZE/2: go to SCORED and pulse `score_r`.
- If dx = 1, no paddle hit, and nx ≥ H_RES−1−BALL_SIZE/2: go to SCORED and pulse `score_l`.
- Precedence within one frame:
  - Paddle hit beats scoring.
  - Wall and paddle hits are applied together.
  - On a score, position is not updated.
- SCORED lasts exactly one cycle, then goes to SERVE:
  - ball re-centred;
  - dx set toward the player who conceded;
  - dy retained;
  - spd = SPEED.
- `pause` high: `frame` is ignored in every state, so there is no counting and no movement.
- Reset state:
  - SERVE, counter = 0;
  - ball_x = H_RES/2, ball_y = V_RES/2;
  - dx = 1, dy = 1, spd = SPEED;
  - `serving` = 1;
  - `score_l` = 0, `score_r` = 0.

## Timing
- `frame` high in cycle N → `ball_x`/`ball_y`/state updated at the clock edge ending N; new values visible in cycle N+1.
- Score pulse: high in N+1 only. SCORED occupies N+1; SERVE with the ball centred from N+2.
- Position changes only in blanking-aligned cycles, so it is stable for the whole active frame.
- `rst` and `frame` in the same cycle: reset wins.
- Reset mid-PLAY: returns to the full reset state in one cycle.
- `frame` during SCORED: ignored.
- A second `frame` before the update completes is impossible by construction (at most one frame per cycle).

## Configuration
- `BALL_CTRL_SPEEDUP_EN` defined:
  - each paddle hit sets spd = min(spd+1, MAX_SPEED);
  - spd is restored to SPEED on serve.
- Not defined: spd is held constant at SPEED, and MAX_SPEED is unused.

## Structure
- `pong_pkg` holds:
  - H_RES/V_RES defaults;
  - state encoding (SERVE = 2'd0, PLAY = 2'd1, SCORED = 2'd2);
  - direction constants shared with the paddle controller.
- One sub-module, `ball_collide`:
  - purely combinational;
  - inputs: x, y, dx, dy, spd, paddle y values;
  - outputs: next x/y/dx/dy plus hit_l, hit_r, miss_l, miss_r;
  - `ball_ctrl` holds the registers and FSM.

## Test plan
- Serve timing: after reset, 59 frames → still SERVE at (320, 240); 60th frame → PLAY, still (320, 240); next frame → (322, 242).
- Top wall: ball at y = 6, dy = 0 → y = 5, dy = 1; next frame y = 7.
- Left paddle hit: x = 32, y = 200, pad_l_y = 200, dx = 0 → x = 30, dx = 1, no score pulse.
- Left miss: pad_l_y = 400, ball reaches x ≤ 5 → `score_r` high exactly one cycle; SERVE centred with dx = 0.
- Pause: `pause` = 1 for 10 frames mid-PLAY → position unchanged; `rst` asserted mid-PLAY → reset values next cycle.
- With `BALL_CTRL_SPEEDUP_EN`: 5 consecutive paddle hits → spd goes 3, 4, 5, 6, 6; after a score, spd returns to 2.
